// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// The optional watchdog is selected with ALU_SEQ_TIMEOUT_EN.
package alu_seq_pkg;

  localparam int ALU_SEQ_WIDTH = 16;

  // Bit positions of the captured ALU flags inside rsp_flags ({n,z,c,v}).
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_watchdog.sv
// RUN-phase watchdog for the ALU sequencer; only built when ALU_SEQ_TIMEOUT_EN is defined.
// expired is high during the LIMIT-th consecutive enabled cycle after a clear.
module alu_seq_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = enable && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation: loads M then Q onto alu_inbus, waits for alu_finish,
// and presents the last two result words plus flags. ALU_SEQ_TIMEOUT_EN adds a RUN watchdog.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH          = ALU_SEQ_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             alu_start,
  output logic [3:0]       alu_s,
  output logic [WIDTH-1:0] alu_inbus,
  input  logic [WIDTH-1:0] alu_outbus,
  input  logic             alu_finish,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both 1;
  // the producer holds valid and payload steady until that edge.

  alu_seq_state_e   state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hist0_q, hist1_q;
  logic [WIDTH-1:0] rsp_hi_q, rsp_lo_q;
  logic [3:0]       rsp_flags_q;
  logic             timeout;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic rsp_err_q;

  // Cleared on the LOAD_Q->RUN edge so every RUN phase gets the full budget.
  alu_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst_b),
    .clear   (state_q == LOAD_Q),
    .enable  (state_q == RUN),
    .expired (timeout)
  );

  assign rsp_err = rsp_err_q;
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout               = 1'b0;
  assign rsp_err               = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hist0_q     <= '0;
      hist1_q     <= '0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_flags_q <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
      end
      if (state_q == LOAD_M || state_q == LOAD_Q || state_q == RUN) begin
        hist1_q <= hist0_q;
        hist0_q <= alu_outbus;
      end
      // Finish takes priority over a coincident timeout.
      if (state_q == RUN) begin
        if (alu_finish) begin
          rsp_hi_q            <= hist1_q;
          rsp_lo_q            <= hist0_q;
          rsp_flags_q[FLAG_N] <= alu_n;
          rsp_flags_q[FLAG_Z] <= alu_z;
          rsp_flags_q[FLAG_C] <= alu_c;
          rsp_flags_q[FLAG_V] <= alu_v;
`ifdef ALU_SEQ_TIMEOUT_EN
          rsp_err_q           <= 1'b0;
        end else if (timeout) begin
          rsp_hi_q            <= '0;
          rsp_lo_q            <= '0;
          rsp_flags_q         <= '0;
          rsp_err_q           <= 1'b1;
`endif
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    alu_start = 1'b0;
    alu_s     = '0;
    alu_inbus = '0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = LOAD_M;
      end
      LOAD_M: begin
        alu_start = 1'b1;
        alu_s     = op_q;
        alu_inbus = b_q;
        state_d   = LOAD_Q;
      end
      LOAD_Q: begin
        alu_s     = op_q;
        alu_inbus = a_q;
        state_d   = RUN;
      end
      RUN: begin
        alu_s = op_q;
        if (alu_finish || timeout) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_flags = rsp_flags_q;
  assign dbg_state = state_q;

endmodule
